spi_ram: RTL

- SPI slave byte memory with READ/WRITE commands, auto-incrementing address and a selectable SPI mode.
- Samples ss/sclk/mosi in the system clock domain; it does not clock on sclk.
- Lets an external master load and read back a BRAM buffer that fabric logic also reads through a local read port.
- Also reports every SPI write to fabric as a one-cycle strobe.

---
 rtl/spi_ram.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_ram.sv
// SPI slave byte memory with READ (0x03) / WRITE (0x02), auto-increment address and a local read port.
// Define SPI_RAM_WEL_EN to add a write-enable latch (0x06 set, 0x04 clear).
// state  | meaning
// IDLE   | deselected, waiting for ss falling
// CMD    | receiving command byte
// ADDR   | receiving address bytes
// RDATA  | streaming memory bytes on miso
// WDATA  | writing received bytes to memory
// IGNORE | unknown command, wait for ss high
module spi_ram #(
   parameter int         ADDR_W    = 4,
   parameter logic [1:0] MODE      = 2'd3,
   parameter string      INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ss,
   input  logic              sclk,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic              wr_stb,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data
);

   localparam logic CPOL  = MODE[1];
   localparam logic CPHA  = MODE[0];
   localparam int   NA    = (ADDR_W + 7) / 8;
   localparam int   DEPTH = 1 << ADDR_W;

   typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

   logic [1:0]        ss_q, sclk_q, mosi_q;
   logic              ss_s, sclk_s, mosi_s, ss_d, sclk_d;
   logic              lead, trail, sample, drive, byte_done, mem_we, wel_ok;
   logic [7:0]        rx_byte;
   logic [ADDR_W+7:0] addr_cat;

   state_t            state;
   logic              op_rd, fetch, load;
   logic [2:0]        bit_cnt;
   logic [1:0]        a_cnt;
   logic [6:0]        rx_sr;
   logic [7:0]        tx_sr, mem_q;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        mem [DEPTH];

`ifdef SPI_RAM_WEL_EN
   logic wel, wr_txn;
   assign wel_ok = wel;
`else
   assign wel_ok = 1'b1;
`endif

   assign ss_s      = ss_q[1];
   assign sclk_s    = sclk_q[1];
   assign mosi_s    = mosi_q[1];
   assign lead      = (sclk_s != sclk_d) && (sclk_s != CPOL);
   assign trail     = (sclk_s != sclk_d) && (sclk_s == CPOL);
   assign sample    = CPHA ? trail : lead;
   assign drive     = CPHA ? lead : trail;
   assign rx_byte   = {rx_sr, mosi_s};
   assign byte_done = sample && (bit_cnt == 3'd7);
   assign addr_cat  = {addr, rx_byte};
   assign mem_we    = !ss_s && (state == WDATA) && byte_done && wel_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q   <= 2'b11;
         sclk_q <= {2{CPOL}};
         mosi_q <= 2'b00;
         ss_d   <= 1'b1;
         sclk_d <= CPOL;
      end else begin
         ss_q   <= {ss_q[0], ss};
         sclk_q <= {sclk_q[0], sclk};
         mosi_q <= {mosi_q[0], mosi};
         ss_d   <= ss_s;
         sclk_d <= sclk_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         op_rd   <= 1'b0;
         fetch   <= 1'b0;
         load    <= 1'b0;
         bit_cnt <= 3'd0;
         a_cnt   <= 2'd0;
         rx_sr   <= 7'd0;
         tx_sr   <= 8'd0;
         addr    <= '0;
         miso    <= 1'b0;
         miso_oe <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         wr_data <= 8'd0;
`ifdef SPI_RAM_WEL_EN
         wel     <= 1'b0;
         wr_txn  <= 1'b0;
`endif
      end else begin
         wr_stb  <= 1'b0;
         miso_oe <= !ss_s;
         fetch   <= 1'b0;
         load    <= fetch;
         // fetch cycle reads mem[addr] into mem_q, so the address can step now
         if (fetch)
            addr <= addr + ADDR_W'(1);
         if (ss_s) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            miso    <= 1'b0;
`ifdef SPI_RAM_WEL_EN
            if (wr_txn) begin
               wel    <= 1'b0;
               wr_txn <= 1'b0;
            end
`endif
         end else begin
            if (sample) begin
               rx_sr   <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (drive && state == RDATA) begin
               miso  <= tx_sr[7];
               tx_sr <= {tx_sr[6:0], 1'b0};
            end
            if (load)
               tx_sr <= mem_q;
            case (state)
               IDLE:
                  if (ss_d)
                     state <= CMD;
               CMD:
                  if (byte_done) begin
                     a_cnt <= 2'd0;
                     case (rx_byte)
                        8'h03: begin
                           op_rd <= 1'b1;
                           state <= ADDR;
                        end
                        8'h02: begin
                           op_rd <= 1'b0;
                           state <= ADDR;
`ifdef SPI_RAM_WEL_EN
                           wr_txn <= 1'b1;
`endif
                        end
`ifdef SPI_RAM_WEL_EN
                        8'h06: begin
                           wel   <= 1'b1;
                           state <= IGNORE;
                        end
                        8'h04: begin
                           wel   <= 1'b0;
                           state <= IGNORE;
                        end
`endif
                        default: state <= IGNORE;
                     endcase
                  end
               ADDR:
                  if (byte_done) begin
                     addr <= addr_cat[ADDR_W-1:0];
                     if (a_cnt == 2'(NA - 1)) begin
                        if (op_rd) begin
                           state <= RDATA;
                           fetch <= 1'b1;
                        end else begin
                           state <= WDATA;
                        end
                     end else begin
                        a_cnt <= a_cnt + 2'd1;
                     end
                  end
               RDATA:
                  if (byte_done)
                     fetch <= 1'b1;
               WDATA:
                  if (byte_done) begin
                     if (mem_we) begin
                        wr_stb  <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= rx_byte;
                     end
                     addr <= addr + ADDR_W'(1);
                  end
               IGNORE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[addr] <= rx_byte;
      if (fetch)
         mem_q <= mem[addr];
   end

   // non-blocking read returns the pre-write byte on a same-cycle SPI write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= 8'd0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule
